// File: rtl/div_issue_ctrl.sv
// Issue controller in front of the iterative divider: resolves RISC-V special cases and
// quotient/remainder reuse in one cycle, sequences the divider otherwise, absorbs flushes.
module div_issue_ctrl #(
  parameter int XLEN         = 32,
  parameter bit ENABLE_REUSE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            div_start,
  output logic            div_is_signed,
  output logic            div_is_rem,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_done,
  input  logic            div_busy
);

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ALL_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              out_valid_r;
  logic [XLEN-1:0]   out_data_r;
  logic [4:0]        out_rd_r;
  logic              op_rem_r, op_signed_r;
  logic [XLEN-1:0]   op_rs1_r, op_rs2_r;
  logic              cache_valid_r, c_signed_r;
  logic [XLEN-1:0]   c_rs1_r, c_rs2_r, c_quot_r, c_rem_r;

  logic              op_signed_s, op_rem_s, div_zero_s, ovf_s, special_s, hit_s, fast_s;
  logic              accept_s, done_take_s;
  logic [XLEN-1:0]   fast_data_s;

  // Divide-by-zero wins over signed overflow; both have fixed architectural results.
  function automatic logic [XLEN-1:0] special_result(input logic is_rem, input logic by_zero,
                                                     input logic [XLEN-1:0] rs1);
    if (by_zero) begin
      return is_rem ? rs1 : ALL_ONES;
    end else begin
      return is_rem ? ALL_ZERO : rs1;
    end
  endfunction

  assign op_signed_s = ~in_op[0];
  assign op_rem_s    = in_op[1];
  assign div_zero_s  = (in_rs2 == ALL_ZERO);
  assign ovf_s       = op_signed_s && (in_rs1 == INT_MIN) && (in_rs2 == ALL_ONES);
  assign special_s   = div_zero_s || ovf_s;
  assign hit_s       = ENABLE_REUSE && cache_valid_r && (in_rs1 == c_rs1_r) &&
                       (in_rs2 == c_rs2_r) && (op_signed_s == c_signed_r);
  assign fast_s      = special_s || hit_s;
  assign fast_data_s = special_s ? special_result(op_rem_s, div_zero_s, in_rs1)
                                 : (op_rem_s ? c_rem_r : c_quot_r);

  assign in_ready    = (state_r == IDLE) && !flush && (fast_s || !div_busy);
  assign accept_s    = in_valid && in_ready;
  assign div_start   = (state_r == IDLE) && in_valid && !flush && !fast_s && !div_busy;
  assign done_take_s = (state_r == WAIT) && div_done && !flush;

  assign div_is_signed = op_signed_s;
  assign div_is_rem    = op_rem_s;
  assign div_dividend  = in_rs1;
  assign div_divisor   = in_rs2;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_rd    = out_rd_r;

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = fast_s ? RESP : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_s = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (flush || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      DRAIN: begin
        if (div_done) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, result registers, in-flight operand latch and reuse cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      out_valid_r   <= 1'b0;
      out_data_r    <= ALL_ZERO;
      out_rd_r      <= 5'd0;
      op_rem_r      <= 1'b0;
      op_signed_r   <= 1'b0;
      op_rs1_r      <= ALL_ZERO;
      op_rs2_r      <= ALL_ZERO;
      cache_valid_r <= 1'b0;
      c_signed_r    <= 1'b0;
      c_rs1_r       <= ALL_ZERO;
      c_rs2_r       <= ALL_ZERO;
      c_quot_r      <= ALL_ZERO;
      c_rem_r       <= ALL_ZERO;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == RESP);
      if (accept_s) begin
        out_rd_r    <= in_rd;
        op_rem_r    <= op_rem_s;
        op_signed_r <= op_signed_s;
        op_rs1_r    <= in_rs1;
        op_rs2_r    <= in_rs2;
        if (fast_s) begin
          out_data_r <= fast_data_s;
        end
      end
      if (done_take_s) begin
        out_data_r    <= op_rem_r ? div_remainder : div_quotient;
        cache_valid_r <= 1'b1;
        c_signed_r    <= op_signed_r;
        c_rs1_r       <= op_rs1_r;
        c_rs2_r       <= op_rs2_r;
        c_quot_r      <= div_quotient;
        c_rem_r       <= div_remainder;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed cases plus randomized ops against a
// reference model of the architectural results, expected latency and the reuse cache.
module tb_div_issue_ctrl;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2, out_data, div_dividend, div_divisor, div_quotient, div_remainder;
  logic [4:0]  in_rd, out_rd;
  logic        div_start, div_is_signed, div_is_rem, div_done, div_busy;

  int n_chk = 0;
  int n_pass = 0;

  // Reference-model reuse cache: the last result that came back from the divider.
  logic        m_valid = 1'b0;
  logic        m_sgn = 1'b0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;

  div_issue_ctrl #(.XLEN(XLEN), .ENABLE_REUSE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .div_start(div_start), .div_is_signed(div_is_signed), .div_is_rem(div_is_rem),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] true_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Divider stand-in: done pulses XLEN+3 cycles after the start cycle.
  logic [31:0] s_a, s_b;
  logic        s_sgn, s_busy;
  int          s_cnt;
  logic [63:0] s_qr;
  always @(posedge clk) begin
    if (reset) begin
      s_busy <= 1'b0;
      s_cnt  <= 0;
    end else if (div_start) begin
      s_busy <= 1'b1;
      s_cnt  <= 0;
      s_a    <= div_dividend;
      s_b    <= div_divisor;
      s_sgn  <= div_is_signed;
    end else if (s_busy) begin
      if (s_cnt == XLEN + 2) s_busy <= 1'b0;
      else s_cnt <= s_cnt + 1;
    end
  end
  assign s_qr          = true_div(s_sgn, s_a, s_b);
  assign div_busy      = s_busy;
  assign div_done      = s_busy && (s_cnt == XLEN + 2);
  assign div_quotient  = s_qr[63:32];
  assign div_remainder = s_qr[31:0];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
  endtask

  function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    qr = true_div(!op[0], a, b);
    return op[1] ? qr[31:0] : qr[63:32];
  endfunction

  function automatic logic ref_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1'b1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return m_valid && (a == m_a) && (b == m_b) && (!op[0] == m_sgn);
  endfunction

  // Present an op and wait until it is accepted; returns just after the accepting edge.
  task automatic accept_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, output logic started);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept", 32'(in_ready), 32'd1);
    started = div_start;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int stall);
    logic exp_fast, st;
    logic [31:0] exp_d;
    int lat, starts;
    exp_fast  = ref_fast(op, a, b);
    exp_d     = ref_calc(op, a, b);
    out_ready = (stall == 0);
    accept_only(op, a, b, rd, st);
    check_eq("start_at_accept", 32'(st), 32'(!exp_fast));
    starts = st ? 1 : 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (div_start) starts++;
    end while (!out_valid && lat < 100);
    check_eq("latency", 32'(lat), exp_fast ? 32'd1 : 32'(XLEN + 4));
    check_eq("data", out_data, exp_d);
    check_eq("rd", 32'(out_rd), 32'(rd));
    check_eq("start_count", 32'(starts), exp_fast ? 32'd0 : 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", out_data, exp_d);
      check_eq("hold_rd", 32'(out_rd), 32'(rd));
    end
    @(negedge clk);
    check_eq("valid_drop", 32'(out_valid), 32'd0);
    check_eq("ready_after", 32'(in_ready), 32'd1);
    if (!exp_fast) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_sgn = !op[0];
    end
  endtask

  initial begin
    logic st, seen_done;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int w;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_rs1 = 32'd0; in_rs2 = 32'd0; in_rd = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_rd", 32'(out_rd), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);

    run_op(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd5, 0);
    run_op(2'b00, 32'd100, 32'd7, 5'd1, 0);
    run_op(2'b10, 32'd100, 32'd7, 5'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd3, 0);
    run_op(2'b01, 32'h0000_1234, 32'd0, 5'd4, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);

    // flush ten cycles into a divide, plus a redundant flush while draining
    accept_only(2'b00, 32'd1000, 32'd33, 5'd8, st);
    check_eq("flush_op_start", 32'(st), 32'd1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("flush_ready", 32'(in_ready), 32'd0);
    w = 0; seen_done = 1'b0;
    while (!seen_done && w < 100) begin
      @(posedge clk); #1;
      flush = (w == 3);
      @(negedge clk);
      check_eq("drain_ready", 32'(in_ready), 32'd0);
      check_eq("drain_valid", 32'(out_valid), 32'd0);
      seen_done = div_done;
      w++;
    end
    check_eq("drain_done_seen", 32'(seen_done), 32'd1);
    @(negedge clk);
    check_eq("post_drain_ready", 32'(in_ready), 32'd1);
    check_eq("post_drain_valid", 32'(out_valid), 32'd0);
    run_op(2'b01, 32'd9, 32'd2, 5'd9, 0);
    run_op(2'b00, 32'd1000, 32'd33, 5'd10, 0);

    // flush in the same cycle as div_done: result discarded, no cache fill
    accept_only(2'b11, 32'd12345, 32'd11, 5'd11, st);
    repeat (34) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("done_flush_cycle", 32'(div_done), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("done_flush_valid", 32'(out_valid), 32'd0);
    check_eq("done_flush_ready", 32'(in_ready), 32'd1);
    run_op(2'b10, 32'd12345, 32'd11, 5'd12, 0);

    // flush while the result is waiting in RESP
    out_ready = 1'b0;
    accept_only(2'b01, 32'd77, 32'd0, 5'd13, st);
    @(negedge clk);
    check_eq("resp_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check_eq("resp_flush_hold", 32'(out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("resp_flush_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    run_op(2'b00, 32'd500, 32'd9, 5'd14, 5);

    // reset in the middle of a divide clears state and cache
    run_op(2'b00, 32'd100, 32'd7, 5'd15, 0);
    accept_only(2'b00, 32'd555, 32'd13, 5'd9, st);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", out_data, 32'd0);
    check_eq("mid_rst_rd", 32'(out_rd), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_start", 32'(div_start), 32'd0);
    m_valid = 1'b0;
    run_op(2'b00, 32'd100, 32'd7, 5'd16, 0);

    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: r_a = 32'h8000_0000;
        1: r_a = $urandom;
        2: r_a = 32'($urandom_range(0, 50));
        3: r_a = m_a;
        default: r_a = 32'hFFFF_FFEC;
      endcase
      case ($urandom_range(0, 4))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_b = 32'($urandom_range(1, 9));
        3: r_b = m_b;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 5'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
